serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl.sv | 118 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell, LSB first, WIDTH cycles per sum.
`timescale 1ns/1ps

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] sum_nx;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_s;
    logic             fa_c;

    full_adder u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_c)
    );

    // Sum bits enter at the MSB so the LSB-first stream lands in place.
    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_nx = fa_s;
        end else begin : g_wn
            assign sum_nx = {fa_s, sum_r[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            sum_r <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        carry <= Cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_r <= sum_nx;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= fa_c;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign Sum  = sum_r;
    assign Cout = carry;

endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1.
`timescale 1ns/1ps

module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    logic start1 = 1'b0;
    logic a1 = 1'b0;
    logic b1 = 1'b0;
    logic cin1 = 1'b0;
    logic busy1;
    logic done1;
    logic sum1;
    logic cout1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (a),
        .B     (b),
        .Cin   (cin),
        .busy  (busy),
        .done  (done),
        .Sum   (sum),
        .Cout  (cout)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .A     (a1),
        .B     (b1),
        .Cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .Sum   (sum1),
        .Cout  (cout1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full operation; noise scrambles inputs while it runs.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input bit noise);
        logic [W:0] exp_r;
        int n;
        bit bok;
        exp_r = {1'b0, x} + {1'b0, y} + (W+1)'(c);
        a = x;
        b = y;
        cin = c;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_on", 32'(busy), 32'd1);
        bok = 1'b1;
        n = 0;
        while (n < 20) begin
            if (noise) begin
                a = W'($urandom);
                b = W'($urandom);
                cin = 1'($urandom);
                start = 1'($urandom);
            end
            tick();
            n++;
            if (done) break;
            if (!busy) bok = 1'b0;
        end
        chk("latency", 32'(n), 32'(W));
        chk("busy_run", 32'(bok), 32'd1);
        chk("sum", 32'(sum), 32'(exp_r[W-1:0]));
        chk("cout", 32'(cout), 32'(exp_r[W]));
        chk("busy_done", 32'(busy), 32'd0);
        start = noise ? 1'($urandom) : 1'b0;
        tick();
        start = 1'b0;
        chk("done_pulse", 32'(done), 32'd0);
        chk("hold_sum", 32'(sum), 32'(exp_r[W-1:0]));
    endtask

    initial begin
        int first;
        int last;
        int cnt;
        int dn;
        bit ok;
        logic [W:0] e8;
        logic [1:0] e1;

        repeat (2) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_w1", {28'd0, busy1, done1, sum1, cout1}, 32'd0);

        rst_n = 1'b1;
        run_op(8'h0F, 8'h01, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
        run_op(8'h00, 8'h00, 1'b0, 1'b0);

        // start re-pulsed mid-run with different operands
        a = 8'h12;
        b = 8'h34;
        cin = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a = 8'h77;
        b = 8'h88;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = '0;
        b = '0;
        cnt = 0;
        first = -1;
        for (int e = 4; e < 30; e++) begin
            tick();
            if (done) begin
                cnt++;
                if (first < 0) first = e;
                chk("repulse_sum", 32'(sum), 32'h46);
            end
        end
        chk("repulse_cnt", 32'(cnt), 32'd1);
        chk("repulse_edge", 32'(first), 32'd8);

        // start held high: one accept every W+2 cycles
        a = 8'h3C;
        b = 8'h5A;
        cin = 1'b1;
        e8 = {1'b0, a} + {1'b0, b} + 9'd1;
        start = 1'b1;
        tick();
        cnt = 0;
        first = -1;
        last = -1;
        ok = 1'b1;
        for (int e = 1; e < 40; e++) begin
            tick();
            if (done) begin
                cnt++;
                if (first < 0) first = e;
                else if (e - last != W + 2) ok = 1'b0;
                last = e;
                if ({cout, sum} !== e8) ok = 1'b0;
            end
        end
        start = 1'b0;
        chk("thru_first", 32'(first), 32'd8);
        chk("thru_cnt", 32'(cnt), 32'd4);
        chk("thru_ok", 32'(ok), 32'd1);
        tick();

        // reset in the middle of a run
        a = 8'hF0;
        b = 8'hF0;
        cin = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        dn = 0;
        repeat (3) begin
            tick();
            if (done) dn++;
        end
        chk("abort_nodone", 32'(dn), 32'd0);
        rst_n = 1'b1;
        run_op(8'h80, 8'h80, 1'b1, 1'b0);

        // WIDTH=1 instance: all input combinations
        for (int k = 0; k < 8; k++) begin
            logic [2:0] kv;
            kv = 3'(k);
            a1 = kv[2];
            b1 = kv[1];
            cin1 = kv[0];
            e1 = 2'(kv[2]) + 2'(kv[1]) + 2'(kv[0]);
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            a1 = ~a1;
            chk("w1_busy", 32'(busy1), 32'd1);
            tick();
            chk("w1_done", 32'(done1), 32'd1);
            chk("w1_res", {30'd0, cout1, sum1}, {30'd0, e1});
            tick();
            chk("w1_idle", 32'(done1), 32'd0);
        end

        for (int i = 0; i < 1000; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
